rocket_motion: RTL and testbench
================================

# rocket_motion

Per-frame vertical physics engine for the lander. Consumes the `upEn`/`downEn` enables from the rocket button controller, integrates velocity and position on a programmable frame tick, burns fuel while thrusting, and reports the landing outcome. Its outputs drive the drawing datapath and the game-over logic.

## Interface

Parameters:
- `TICK_DIV`, default 833333: clock cycles per physics frame (60 Hz at 50 MHz). Must be ≥ 2.
- `Y_START`, default 0: initial row on launch.
- `Y_MAX`, default 112: ground row, 7-bit value.
- `V_SAFE`, default 2: maximum downward speed for a soft landing.
- `V_MAX`, default 7: velocity saturation magnitude.
- `FUEL_INIT`, default 255: fuel units loaded on launch.

Ports:
- `Clock`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-low.
- `upEn`, in, 1: thrust request (upward acceleration).
- `downEn`, in, 1: dive request (extra downward acceleration).
- `start`, in, 1: launch or relaunch pulse.
- `y`, out, 7: rocket row; 0 is the top of the screen.
- `vel`, out, 5: signed two's-complement velocity in rows/frame; positive means down.
- `fuel`, out, 8: remaining fuel.
- `tick`, out, 1: one-cycle frame strobe.
- `active`, out, 1: high while in FLY.
- `landed`, out, 1: sticky; high in LANDED.
- `crashed`, out, 1: sticky; high in CRASHED.

## Operation

- States: IDLE, FLY, LANDED, CRASHED. Reset enters IDLE.
- `start` sampled high in IDLE, LANDED or CRASHED:
  - next state is FLY;
  - `y` ← `Y_START`, `vel` ← 0, `fuel` ← `FUEL_INIT`;
  - frame counter reloads to `TICK_DIV`−1.
- `start` is ignored in FLY.
- Frame counter:
  - free-running down-counter in every state;
  - reloads to `TICK_DIV`−1 after reaching 0;
  - `tick` = (counter == 0).
- Physics update happens only in FLY, on the edge that ends a `tick` cycle.
- Acceleration, in priority order:
  - `upEn`=1 and `fuel`>0: a = −1, `fuel` decrements by 1.
  - else `downEn`=1: a = +2.
  - else: a = +1 (gravity).
  - `upEn` with `fuel`=0 is treated as no thrust.
  - `upEn` and `downEn` both high: `upEn` wins.
- Velocity: v' = clamp(vel + a, −`V_MAX`, +`V_MAX`).
- Position: p = y + v', computed at 9-bit signed width.
  - p < 0: `y` ← 0, `vel` ← 0 (ceiling); stay in FLY.
  - p ≥ `Y_MAX`: `y` ← `Y_MAX`, `vel` ← 0.
    - v' ≤ `V_SAFE`: go to LANDED.
    - otherwise: go to CRASHED.
  - else: `y` ← p, `vel` ← v'.
- Outside FLY, `y`, `vel` and `fuel` hold their values. `upEn` and `downEn` are ignored.

## Timing

- All outputs are registered.
- Reset values: `y`=`Y_START`, `vel`=0, `fuel`=`FUEL_INIT`, `active`=0, `landed`=0, `crashed`=0.
- After reset, counter = `TICK_DIV`−1, so `tick` first asserts `TICK_DIV` cycles after reset deasserts.
- The `start` edge forces FLY and reloads the counter. The first physics update therefore lands `TICK_DIV` cycles later.
- `y`, `vel`, `fuel` and the state change on the edge ending the `tick` cycle. New values are visible the following cycle.
- `upEn` and `downEn` are sampled only during the `tick` cycle.
- `landed` and `crashed` assert the cycle after the terminating tick. They hold until `start` or `Reset`.
- `Reset` low mid-flight returns everything to reset values on the next edge, regardless of `tick`.

## Test plan

Common settings: `TICK_DIV`=4, `Y_MAX`=20, `V_SAFE`=2, `Y_START`=0, `FUEL_INIT`=255 unless stated.

1. **Reset.** Hold `Reset`=0 for 2 cycles, then release → outputs 0/0/255/0/0/0; first `tick` 4 cycles later; no motion without `start`.
2. **Free fall to crash.** `start`, no inputs → after successive ticks (`vel`,`y`) = (1,1),(2,3),(3,6),(4,10),(5,15); sixth tick gives `y`=20, `vel`=0, `crashed`=1, `active`=0.
3. **Ceiling and fuel exhaustion.** `FUEL_INIT`=2, hold `upEn` → ticks 1–2: `y`=0, `vel`=0, `fuel` 1 then 0; tick 3: `vel`=1, `y`=1, `fuel` stays 0.
4. **Soft landing.** `Y_START`=18, no inputs → tick 1: `y`=19, `vel`=1; tick 2: `y`=20, `landed`=1, `crashed`=0.
5. **Priority and dive.** `upEn`=`downEn`=1 for 1 tick, then `downEn` only for 1 tick, from `y`=0 → tick 1: `fuel`=254, `vel`=0, `y`=0; tick 2: `vel`=2, `y`=2.
6. **Restart and mid-flight reset.** `start` held during FLY → no reload. `start` in CRASHED → FLY with `y`=`Y_START`, `fuel`=255. `Reset`=0 mid-flight → all reset values next cycle.

Source files
------------

// File: rtl/rocket_motion.sv
`default_nettype none
// ============================================================================
// Module   : rocket_motion
// Purpose  : Per-frame vertical physics for the lander. A free-running frame
//            counter produces a one-cycle tick. On every tick while flying,
//            thrust/dive/gravity is applied to the velocity and the position
//            is integrated. Thrust burns fuel, and touching the ground ends
//            the flight as a soft landing or a crash.
// Ports    : Clock   - system clock
//            Reset   - synchronous, active-low reset
//            upEn    - thrust request (acceleration -1, burns one fuel unit)
//            downEn  - dive request (acceleration +2)
//            start   - launch / relaunch pulse (ignored while flying)
//            y       - rocket row, 0 = top of screen
//            vel     - signed velocity in rows/frame, positive = down
//            fuel    - remaining fuel units
//            tick    - one-cycle frame strobe
//            active  - high while flying
//            landed  - sticky soft-landing flag
//            crashed - sticky crash flag
// Revision : 1.0 - initial release
// ============================================================================
module rocket_motion #(
  parameter int TICK_DIV  = 833333,
  parameter int Y_START   = 0,
  parameter int Y_MAX     = 112,
  parameter int V_SAFE    = 2,
  parameter int V_MAX     = 7,
  parameter int FUEL_INIT = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       upEn,
  input  logic       downEn,
  input  logic       start,
  output logic [6:0] y,
  output logic [4:0] vel,
  output logic [7:0] fuel,
  output logic       tick,
  output logic       active,
  output logic       landed,
  output logic       crashed
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]  c_cnt_reload = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]        c_y_start    = 7'(Y_START);
  localparam logic [6:0]        c_y_max      = 7'(Y_MAX);
  localparam logic [7:0]        c_fuel_init  = 8'(FUEL_INIT);
  localparam logic signed [5:0] c_v_max      = 6'(V_MAX);
  localparam logic signed [5:0] c_v_min      = 6'(-V_MAX);
  localparam logic signed [5:0] c_v_safe     = 6'(V_SAFE);
  localparam logic signed [8:0] c_y_max_s    = 9'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLY     = 2'd1,
    S_LANDED  = 2'd2,
    S_CRASHED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [6:0]       y_q, y_d;
  logic [4:0]       vel_q, vel_d;
  logic [7:0]       fuel_q, fuel_d;
  logic             active_q, active_d;
  logic             landed_q, landed_d;
  logic             crashed_q, crashed_d;

  // Physics datapath, evaluated every cycle; only committed on a flying tick.
  logic              thrust;
  logic signed [5:0] accel;
  logic signed [5:0] vel_sum;
  logic signed [5:0] vel_clamped;
  logic signed [8:0] pos;

  always_comb begin
    thrust = upEn && (fuel_q != 8'd0);
    if (thrust) begin
      accel = -6'sd1;
    end else if (downEn) begin
      accel = 6'sd2;
    end else begin
      accel = 6'sd1;
    end

    // One extra bit of headroom so the sum cannot wrap before clamping.
    vel_sum = $signed({vel_q[4], vel_q}) + accel;
    if (vel_sum > c_v_max) begin
      vel_clamped = c_v_max;
    end else if (vel_sum < c_v_min) begin
      vel_clamped = c_v_min;
    end else begin
      vel_clamped = vel_sum;
    end

    pos = $signed({2'b00, y_q}) + $signed({{3{vel_clamped[5]}}, vel_clamped});
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    fuel_d  = fuel_q;
    cnt_d   = (cnt_q == '0) ? c_cnt_reload : cnt_q - 1'b1;

    if (start && (state_q != S_FLY)) begin
      // Launch realigns the frame so the first update is a full frame away.
      state_d = S_FLY;
      y_d     = c_y_start;
      vel_d   = 5'd0;
      fuel_d  = c_fuel_init;
      cnt_d   = c_cnt_reload;
    end else if ((state_q == S_FLY) && tick_q) begin
      if (thrust) begin
        fuel_d = fuel_q - 8'd1;
      end
      if (pos < 9'sd0) begin
        // Hit the ceiling: pin to the top and kill the upward speed.
        y_d   = 7'd0;
        vel_d = 5'd0;
      end else if (pos >= c_y_max_s) begin
        y_d     = c_y_max;
        vel_d   = 5'd0;
        state_d = (vel_clamped <= c_v_safe) ? S_LANDED : S_CRASHED;
      end else begin
        y_d   = pos[6:0];
        vel_d = vel_clamped[4:0];
      end
    end

    // Status outputs are registered copies of the next-state decode.
    tick_d    = (cnt_d == '0);
    active_d  = (state_d == S_FLY);
    landed_d  = (state_d == S_LANDED);
    crashed_d = (state_d == S_CRASHED);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= c_cnt_reload;
      tick_q    <= 1'b0;
      y_q       <= c_y_start;
      vel_q     <= 5'd0;
      fuel_q    <= c_fuel_init;
      active_q  <= 1'b0;
      landed_q  <= 1'b0;
      crashed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      fuel_q    <= fuel_d;
      active_q  <= active_d;
      landed_q  <= landed_d;
      crashed_q <= crashed_d;
    end
  end

  assign y       = y_q;
  assign vel     = vel_q;
  assign fuel    = fuel_q;
  assign tick    = tick_q;
  assign active  = active_q;
  assign landed  = landed_q;
  assign crashed = crashed_q;

endmodule
`default_nettype wire

// File: tb/tb_rocket_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_rocket_motion
// Purpose  : Self-checking bench for rocket_motion. A behavioural model of the
//            frame physics (plain integer arithmetic) runs in lock-step with
//            the design; directed frame sequences additionally check fixed
//            values, followed by a randomized flight phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rocket_motion;

  localparam int TD = 4;
  localparam int YS = 0;
  localparam int YM = 20;
  localparam int VS = 2;
  localparam int VM = 7;
  localparam int FI = 255;

  localparam int M_IDLE    = 0;
  localparam int M_FLY     = 1;
  localparam int M_LANDED  = 2;
  localparam int M_CRASHED = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       upEn;
  logic       downEn;
  logic       start;
  logic [6:0] y;
  logic [4:0] vel;
  logic [7:0] fuel;
  logic       tick;
  logic       active;
  logic       landed;
  logic       crashed;

  int n_vec = 0;
  int n_err = 0;

  int m_state;
  int m_y;
  int m_vel;
  int m_fuel;
  int m_cnt;

  always #5 Clock = ~Clock;

  rocket_motion #(
    .TICK_DIV (TD),
    .Y_START  (YS),
    .Y_MAX    (YM),
    .V_SAFE   (VS),
    .V_MAX    (VM),
    .FUEL_INIT(FI)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .upEn   (upEn),
    .downEn (downEn),
    .start  (start),
    .y      (y),
    .vel    (vel),
    .fuel   (fuel),
    .tick   (tick),
    .active (active),
    .landed (landed),
    .crashed(crashed)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: advance one clock using the inputs present before the edge.
  task automatic model_step();
    int  a;
    int  v;
    int  p;
    int  nc;
    bit  tk;
    if (Reset == 1'b0) begin
      m_state = M_IDLE;
      m_y     = YS;
      m_vel   = 0;
      m_fuel  = FI;
      m_cnt   = TD - 1;
    end else begin
      tk = (m_cnt == 0);
      nc = tk ? TD - 1 : m_cnt - 1;
      if (start && m_state != M_FLY) begin
        m_state = M_FLY;
        m_y     = YS;
        m_vel   = 0;
        m_fuel  = FI;
        nc      = TD - 1;
      end else if (m_state == M_FLY && tk) begin
        if (upEn && m_fuel > 0) begin
          a = -1;
          m_fuel--;
        end else if (downEn) begin
          a = 2;
        end else begin
          a = 1;
        end
        v = m_vel + a;
        if (v > VM) v = VM;
        if (v < -VM) v = -VM;
        p = m_y + v;
        if (p < 0) begin
          m_y   = 0;
          m_vel = 0;
        end else if (p >= YM) begin
          m_y     = YM;
          m_vel   = 0;
          m_state = (v <= VS) ? M_LANDED : M_CRASHED;
        end else begin
          m_y   = p;
          m_vel = v;
        end
      end
      m_cnt = nc;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clock);
    #1;
    chk("y",       y,               m_y);
    chk("vel",     $signed(vel),    m_vel);
    chk("fuel",    fuel,            m_fuel);
    chk("tick",    tick,            (m_cnt == 0) ? 1 : 0);
    chk("active",  active,          (m_state == M_FLY) ? 1 : 0);
    chk("landed",  landed,          (m_state == M_LANDED) ? 1 : 0);
    chk("crashed", crashed,         (m_state == M_CRASHED) ? 1 : 0);
  endtask

  task automatic launch();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic frame(input bit up, input bit dn);
    upEn   = up;
    downEn = dn;
    repeat (TD) cycle();
    upEn   = 1'b0;
    downEn = 1'b0;
  endtask

  initial begin
    int ff_vel [5] = '{1, 2, 3, 4, 5};
    int ff_y   [5] = '{1, 3, 6, 10, 15};
    bit land_up [10] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0};

    Reset  = 1'b0;
    upEn   = 1'b0;
    downEn = 1'b0;
    start  = 1'b0;

    // Reset and first tick timing.
    repeat (2) cycle();
    chk("rst_y",      y,      0);
    chk("rst_vel",    vel,    0);
    chk("rst_fuel",   fuel,   255);
    chk("rst_active", active, 0);
    chk("rst_landed", landed, 0);
    chk("rst_crash",  crashed, 0);
    Reset = 1'b1;
    repeat (2) cycle();
    chk("tick_early", tick, 0);
    cycle();
    chk("tick_first", tick, 1);
    repeat (6) cycle();
    chk("idle_y", y, 0);

    // Free fall to a crash.
    launch();
    chk("launch_active", active, 1);
    for (int i = 0; i < 5; i++) begin
      frame(0, 0);
      chk("ff_vel", $signed(vel), ff_vel[i]);
      chk("ff_y",   y,            ff_y[i]);
    end
    frame(0, 0);
    chk("crash_y",      y,       20);
    chk("crash_vel",    vel,     0);
    chk("crash_flag",   crashed, 1);
    chk("crash_active", active,  0);
    repeat (5) cycle();
    chk("crash_sticky", crashed, 1);

    // Relaunch from CRASHED, holding start into FLY (must not reload).
    start = 1'b1;
    repeat (6) cycle();
    start = 1'b0;
    chk("relaunch_active", active, 1);
    chk("relaunch_crash",  crashed, 0);
    chk("relaunch_fuel",   fuel, 255);
    // Fresh launch to align frames for the priority test.
    Reset = 1'b0;
    cycle();
    Reset = 1'b1;
    launch();
    frame(1, 1);
    chk("prio_fuel", fuel, 254);
    chk("prio_vel",  vel,  0);
    chk("prio_y",    y,    0);
    frame(0, 1);
    chk("dive_vel", $signed(vel), 2);
    chk("dive_y",   y,            2);

    // Mid-flight reset.
    repeat (2) cycle();
    Reset = 1'b0;
    cycle();
    chk("mrst_y",      y,      0);
    chk("mrst_vel",    vel,    0);
    chk("mrst_fuel",   fuel,   255);
    chk("mrst_active", active, 0);
    Reset = 1'b1;
    cycle();

    // Controlled descent to a soft landing.
    launch();
    foreach (land_up[i]) frame(land_up[i], 0);
    chk("soft_landed", landed,  1);
    chk("soft_crash",  crashed, 0);
    chk("soft_y",      y,       20);

    // Hover at the ceiling until fuel runs out.
    launch();
    for (int i = 0; i < 255; i++) frame(1, 0);
    chk("dry_fuel", fuel, 0);
    chk("dry_y",    y,    0);
    chk("dry_vel",  vel,  0);
    frame(1, 0);
    chk("dry_vel2", $signed(vel), 1);
    chk("dry_y2",   y,            1);
    chk("dry_fuel2", fuel,        0);

    // Randomized flight against the model.
    for (int i = 0; i < 4000; i++) begin
      upEn   = ($urandom_range(0, 99) < ((i < 2000) ? 70 : 35));
      downEn = ($urandom_range(0, 99) < 30);
      start  = ($urandom_range(0, 99) < 4);
      Reset  = ($urandom_range(0, 999) >= 3);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
